phase_gen: RTL and testbench

Multi-cycle phase sequencer for the MIPS core. It drives the one-hot phase vector `p[4:0]` consumed by the control unit. It also sets the per-instruction phase count from the opcode/funct held in the instruction register. It sits directly upstream of the CPU top, which takes `p` as its phase input. It adds memory-wait stalls, halt/illegal-opcode detection and a retired-instruction counter.

---
 rtl/phase_gen_pkg.sv | 56 +++++
 rtl/phase_class_dec.sv | 26 ++
 rtl/phase_gen.sv | 121 ++++++++++++
 tb/tb_phase_gen.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_gen_pkg.sv
// Shared constants and types for the multi-cycle phase sequencer.
// Opcode values, phase bit positions, FSM states and instruction classes.
package phase_gen_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    localparam int PH_IF  = 0;
    localparam int PH_ID  = 1;
    localparam int PH_EX  = 2;
    localparam int PH_MEM = 3;
    localparam int PH_WB  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_R,
        C_ADDI,
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_JAL,
        C_SYS,
        C_ILL
    } iclass_t;

    function automatic logic [4:0] ph_onehot(state_t s);
        logic [4:0] v;
        v = '0;
        case (s)
            S_IF:    v[PH_IF]  = 1'b1;
            S_ID:    v[PH_ID]  = 1'b1;
            S_EX:    v[PH_EX]  = 1'b1;
            S_MEM:   v[PH_MEM] = 1'b1;
            S_WB:    v[PH_WB]  = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/phase_class_dec.sv
// Combinational opcode/funct classifier.
// Anything not explicitly recognised is reported as illegal.
module phase_class_dec
    import phase_gen_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output iclass_t    cls
);

    always_comb begin
        cls = C_ILL;
        unique case (1'b1)
            (op == OP_RTYPE && funct == FN_SYSCALL): cls = C_SYS;
            (op == OP_RTYPE && funct != FN_SYSCALL): cls = C_R;
            (op == OP_ADDI):                         cls = C_ADDI;
            (op == OP_LW):                           cls = C_LW;
            (op == OP_SW):                           cls = C_SW;
            (op == OP_BEQ):                          cls = C_BEQ;
            (op == OP_J):                            cls = C_J;
            (op == OP_JAL):                          cls = C_JAL;
            default:                                 cls = C_ILL;
        endcase
    end

endmodule

// File: rtl/phase_gen.sv
// Multi-cycle phase sequencer: one-hot phase vector, memory-wait stalls,
// halt/illegal detection and a retired-instruction counter.
module phase_gen
    import phase_gen_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             pause,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic [4:0]       p,
    output logic             instr_done,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t  state, state_d, bnd;
    iclass_t dec_cls, cls_q, cls_d;
    logic    done_d, halt_d, ill_d;

    phase_class_dec u_dec (
        .op    (op),
        .funct (funct),
        .cls   (dec_cls)
    );

    // Where to go once an instruction retires.
    assign bnd = (pause || !run) ? S_IDLE : S_IF;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cls_q <= C_ILL;
        end else begin
            state <= state_d;
            cls_q <= cls_d;
        end
    end

    always_comb begin
        state_d = state;
        cls_d   = cls_q;
        done_d  = 1'b0;
        halt_d  = 1'b0;
        ill_d   = 1'b0;
        case (state)
            S_IDLE: if (run && !pause) state_d = S_IF;
            S_IF:   if (mem_ready) state_d = S_ID;
            S_ID: begin
                cls_d = dec_cls;
                unique case (dec_cls)
                    C_J: begin
                        state_d = bnd;
                        done_d  = 1'b1;
                    end
                    C_JAL: state_d = S_WB;
                    C_SYS: begin
                        state_d = S_HALT;
                        halt_d  = 1'b1;
                    end
                    C_ILL: begin
                        state_d = S_HALT;
                        halt_d  = 1'b1;
                        ill_d   = 1'b1;
                    end
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                unique case (cls_q)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ: begin
                        state_d = bnd;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls_q == C_SW) begin
                        state_d = bnd;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = bnd;
                done_d  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p           <= '0;
            instr_done  <= 1'b0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            p          <= ph_onehot(state_d);
            instr_done <= done_d;
            if (halt_d) halted  <= 1'b1;
            if (ill_d)  illegal <= 1'b1;
            if (done_d) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_phase_gen.sv
// Self-checking bench for phase_gen: vector table, directed corner cases
// and randomized instruction streams against an instruction-level model.
module tb_phase_gen;

    localparam logic [4:0] F = 5'b00001;
    localparam logic [4:0] D = 5'b00010;
    localparam logic [4:0] E = 5'b00100;
    localparam logic [4:0] M = 5'b01000;
    localparam logic [4:0] W = 5'b10000;
    localparam logic [4:0] Z = 5'b00000;

    typedef struct {
        logic [5:0]      op;
        logic [5:0]      funct;
        int              len;
        logic [4:0][4:0] seq;
        bit              halt;
        bit              ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        pause = 1'b0;
    logic        mem_ready = 1'b0;
    logic [5:0]  op = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  p, p4;
    logic        instr_done, halted, illegal;
    logic        done4, halted4, illegal4;
    logic [31:0] instr_count;
    logic [3:0]  cnt4;

    int pass_n = 0;
    int total_n = 0;
    vec_t vt[10];

    always #5 clk = ~clk;

    phase_gen #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pause       (pause),
        .op          (op),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .p           (p),
        .instr_done  (instr_done),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    phase_gen #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pause       (pause),
        .op          (op),
        .funct       (funct),
        .mem_ready   (mem_ready),
        .p           (p4),
        .instr_done  (done4),
        .halted      (halted4),
        .illegal     (illegal4),
        .instr_count (cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mkv(logic [5:0] o, logic [5:0] f,
                                 logic [4:0] s0, logic [4:0] s1,
                                 logic [4:0] s2, logic [4:0] s3,
                                 logic [4:0] s4, bit h, bit il);
        vec_t v;
        v.op = o;
        v.funct = f;
        v.seq[0] = s0;
        v.seq[1] = s1;
        v.seq[2] = s2;
        v.seq[3] = s3;
        v.seq[4] = s4;
        v.halt = h;
        v.ill = il;
        v.len = 0;
        for (int i = 0; i < 5; i++)
            if (v.seq[i] != 5'd0) v.len++;
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0;
        pause = 1'b0;
        mem_ready = 1'b0;
        op = '0;
        funct = '0;
        #1;
        chk("rst_p", 32'(p), 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_done", 32'(instr_done), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_random(input int n);
        int          exp_cnt;
        bit          exp_done;
        int          c, wi, wm;
        logic [5:0]  rop, rfn;
        logic [4:0]  ph[$];
        bit          mr[$];
        exp_cnt = 0;
        exp_done = 0;
        do_reset();
        run = 1'b1;
        for (int k = 0; k < n; k++) begin
            c  = int'($urandom_range(0, 6));
            wi = int'($urandom_range(0, 3));
            wm = int'($urandom_range(0, 3));
            ph.delete();
            mr.delete();
            for (int w = 0; w < wi; w++) begin
                ph.push_back(F); mr.push_back(0);
            end
            ph.push_back(F); mr.push_back(1);
            ph.push_back(D); mr.push_back(0);
            rfn = 6'($urandom);
            case (c)
                0: begin
                    rop = 6'b000000;
                    if (rfn == 6'b001100) rfn = 6'b100000;
                end
                1: rop = 6'b001000;
                2: rop = 6'b100011;
                3: rop = 6'b101011;
                4: rop = 6'b000100;
                5: rop = 6'b000010;
                default: rop = 6'b000011;
            endcase
            if (c <= 4) begin
                ph.push_back(E); mr.push_back(0);
            end
            if (c == 2 || c == 3) begin
                for (int w = 0; w < wm; w++) begin
                    ph.push_back(M); mr.push_back(0);
                end
                ph.push_back(M); mr.push_back(1);
            end
            if (c <= 2 || c == 6) begin
                ph.push_back(W); mr.push_back(0);
            end
            for (int j = 0; j < ph.size(); j++) begin
                @(negedge clk);
                chk($sformatf("rnd%0d_p%0d", k, j), 32'(p), 32'(ph[j]));
                chk($sformatf("rnd%0d_done%0d", k, j), 32'(instr_done),
                    32'(exp_done));
                chk($sformatf("rnd%0d_cnt%0d", k, j), instr_count, exp_cnt);
                if (j == 0) begin
                    op = rop;
                    funct = rfn;
                end
                if (ph[j] == F || ph[j] == M) mem_ready = mr[j];
                else mem_ready = 1'($urandom);
                if (j == ph.size() - 1) begin
                    run = 1'b1;
                    pause = 1'b0;
                    exp_done = 1;
                    exp_cnt++;
                end else begin
                    run = 1'($urandom);
                    pause = 1'($urandom);
                    exp_done = 0;
                end
            end
        end
        @(negedge clk);
        chk("rnd_end_p", 32'(p), 32'(F));
        chk("rnd_end_done", 32'(instr_done), 32'(exp_done));
        chk("rnd_end_cnt", instr_count, exp_cnt);
    endtask

    initial begin
        vt[0] = mkv(6'b000000, 6'b100000, F, D, E, W, Z, 0, 0);
        vt[1] = mkv(6'b001000, 6'b000000, F, D, E, W, Z, 0, 0);
        vt[2] = mkv(6'b100011, 6'b000000, F, D, E, M, W, 0, 0);
        vt[3] = mkv(6'b101011, 6'b000000, F, D, E, M, Z, 0, 0);
        vt[4] = mkv(6'b000100, 6'b000000, F, D, E, Z, Z, 0, 0);
        vt[5] = mkv(6'b000010, 6'b000000, F, D, Z, Z, Z, 0, 0);
        vt[6] = mkv(6'b000011, 6'b000000, F, D, W, Z, Z, 0, 0);
        vt[7] = mkv(6'b000000, 6'b001100, F, D, Z, Z, Z, 1, 0);
        vt[8] = mkv(6'b111111, 6'b000000, F, D, Z, Z, Z, 1, 1);
        vt[9] = mkv(6'b000101, 6'b000000, F, D, Z, Z, Z, 1, 1);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            run = 1'b1;
            mem_ready = 1'b1;
            op = vt[i].op;
            funct = vt[i].funct;
            for (int j = 0; j < vt[i].len; j++) begin
                @(negedge clk);
                chk($sformatf("tbl%0d_p%0d", i, j), 32'(p),
                    32'(vt[i].seq[j]));
            end
            @(negedge clk);
            if (vt[i].halt) begin
                chk($sformatf("tbl%0d_halt_p", i), 32'(p), 0);
                chk($sformatf("tbl%0d_halted", i), 32'(halted), 1);
                chk($sformatf("tbl%0d_illegal", i), 32'(illegal),
                    32'(vt[i].ill));
                chk($sformatf("tbl%0d_nodone", i), 32'(instr_done), 0);
                repeat (3) @(negedge clk);
                chk($sformatf("tbl%0d_hold_p", i), 32'(p), 0);
                chk($sformatf("tbl%0d_hold_halted", i), 32'(halted), 1);
                chk($sformatf("tbl%0d_hold_cnt", i), instr_count, 0);
            end else begin
                chk($sformatf("tbl%0d_next_p", i), 32'(p), 32'(F));
                chk($sformatf("tbl%0d_done", i), 32'(instr_done), 1);
                chk($sformatf("tbl%0d_cnt", i), instr_count, 1);
            end
        end

        // j retires, then reset lands in the EX phase of a following lw
        do_reset();
        run = 1'b1;
        mem_ready = 1'b1;
        op = 6'b000010;
        repeat (3) @(negedge clk);
        chk("rstmid_cnt_before", instr_count, 1);
        op = 6'b100011;
        repeat (2) @(negedge clk);
        chk("rstmid_in_ex", 32'(p), 32'(E));
        #2 reset = 1'b0;
        #1;
        chk("rstmid_p", 32'(p), 0);
        chk("rstmid_cnt", instr_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_restart_p", 32'(p), 32'(F));

        // sw with three MEM wait cycles
        do_reset();
        run = 1'b1;
        mem_ready = 1'b1;
        op = 6'b101011;
        repeat (3) @(negedge clk);
        chk("sw_ex", 32'(p), 32'(E));
        mem_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("sw_mem%0d_p", j), 32'(p), 32'(M));
            chk($sformatf("sw_mem%0d_done", j), 32'(instr_done), 0);
            mem_ready = (j == 3);
        end
        @(negedge clk);
        chk("sw_exit_p", 32'(p), 32'(F));
        chk("sw_exit_done", 32'(instr_done), 1);
        chk("sw_exit_cnt", instr_count, 1);
        @(negedge clk);
        chk("sw_pulse_once", 32'(instr_done), 0);
        chk("sw_cnt_once", instr_count, 1);

        // pause raised in EX of an R-type
        do_reset();
        run = 1'b1;
        mem_ready = 1'b1;
        op = 6'b000000;
        funct = 6'b100001;
        repeat (3) @(negedge clk);
        chk("pause_ex", 32'(p), 32'(E));
        pause = 1'b1;
        @(negedge clk);
        chk("pause_wb", 32'(p), 32'(W));
        @(negedge clk);
        chk("pause_idle_p", 32'(p), 0);
        chk("pause_idle_done", 32'(instr_done), 1);
        chk("pause_idle_cnt", instr_count, 1);
        pause = 1'b0;
        @(negedge clk);
        chk("pause_resume_p", 32'(p), 32'(F));

        // 16 back-to-back beq on the 4-bit counter
        do_reset();
        run = 1'b1;
        mem_ready = 1'b1;
        op = 6'b000100;
        repeat (46) @(negedge clk);
        chk("wrap_cnt4_15", 32'(cnt4), 15);
        repeat (3) @(negedge clk);
        chk("wrap_cnt4_0", 32'(cnt4), 0);
        chk("wrap_cnt32_16", instr_count, 16);
        chk("wrap_done4", 32'(done4), 1);

        run_random(60);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
